// File: rtl/rev_counter_seq_pkg.sv
// rev_counter_seq_pkg: shared encodings for the reversible-counter sequencer.
package rev_counter_seq_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_END   = 2'd3
    } state_t;
    localparam logic       DIR_UP        = 1'b1;
    localparam logic [3:0] LES_BLINK_ALL = 4'b1111;
    localparam logic [3:0] LES_NONE      = 4'b0000;
    localparam logic [3:0] POINTS_OFF    = 4'b1111;
    localparam logic [3:0] POINTS_DOWN   = 4'b1110;
    function automatic logic [3:0] points_for(input logic dir);
        return (dir == DIR_UP) ? POINTS_OFF : POINTS_DOWN;
    endfunction
endpackage

// File: rtl/rev_counter_seq_if.sv
// rev_counter_seq_if: buttons, counter control and display control around the sequencer.
interface rev_counter_seq_if;
    import rev_counter_seq_pkg::*;
    logic       btn_run, btn_dir, btn_clr, auto_rev, Rc;
    logic       cnt_en, cnt_dir, cnt_clr;
    state_t     state;
    logic [3:0] LES, points;
    modport master (
        input  btn_run, btn_dir, btn_clr, auto_rev, Rc,
        output cnt_en, cnt_dir, cnt_clr, state, LES, points
    );
    modport slave (
        output btn_run, btn_dir, btn_clr, auto_rev, Rc,
        input  cnt_en, cnt_dir, cnt_clr, state, LES, points
    );
endinterface

// File: rtl/rev_counter_seq_btn_debounce.sv
// btn_debounce: synchronises a raw button, accepts a level after DB_CYCLES stable
// cycles, and emits a one-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic RST_n,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic          r_s1, r_s2, r_level, r_level_d, r_press;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (!RST_n) begin
            {r_s1, r_s2, r_level, r_level_d, r_press} <= '0;
            r_cnt <= '0;
        end else begin
            r_s1      <= raw;
            r_s2      <= r_s1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign level = r_level;
    assign press = r_press;
endmodule

// File: rtl/rev_counter_seq.sv
// rev_counter_seq: run/pause/end sequencer pacing the 16-bit reversible counter with
// single-clock tick enables and driving the display blink/point controls.
module rev_counter_seq
    import rev_counter_seq_pkg::*;
#(
    parameter int TICK_DIV  = 10000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              RST_n,
    rev_counter_seq_if.master bus
);
    localparam int            PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    logic          w_run_p, w_dir_p, w_clr_p, w_run, w_dir, w_clr;
    logic          w_due, w_en, w_dir_n, w_pend;
    logic [PW-1:0] w_presc;
    state_t        w_state;
    state_t        r_state;
    logic          r_cnt_en, r_cnt_dir, r_cnt_clr, r_pend;
    logic [3:0]    r_les, r_points;
    logic [PW-1:0] r_presc;
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk(clk), .RST_n(RST_n), .raw(bus.btn_run), .level(), .press(w_run_p)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .clk(clk), .RST_n(RST_n), .raw(bus.btn_dir), .level(), .press(w_dir_p)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk(clk), .RST_n(RST_n), .raw(bus.btn_clr), .level(), .press(w_clr_p)
    );
    assign w_clr = w_clr_p;
    assign w_run = w_run_p & ~w_clr_p;
    assign w_dir = w_dir_p & ~w_run_p & ~w_clr_p;
    assign w_due = (r_presc == P_LAST) | r_pend;
    always_comb begin
        w_state = r_state;
        w_dir_n = r_cnt_dir;
        w_en    = 1'b0;
        w_pend  = r_pend;
        w_presc = r_presc;
        if (w_clr) begin
            w_state = S_IDLE;
            w_presc = '0;
            w_pend  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state = w_run ? S_RUN : S_IDLE;
                    w_presc = '0;
                    w_pend  = 1'b0;
                    w_dir_n = r_cnt_dir ^ w_dir;
                end
                S_PAUSE: begin
                    w_state = w_run ? S_RUN : S_PAUSE;
                    w_dir_n = r_cnt_dir ^ w_dir;
                end
                S_END: begin
                    w_state = w_dir ? S_PAUSE : S_END;
                    w_dir_n = r_cnt_dir ^ w_dir;
                end
                default: begin
                    if (w_run) begin
                        w_state = S_PAUSE;
                    end else begin
                        w_presc = (r_presc == P_LAST) ? '0 : r_presc + 1'b1;
                        // a tick meeting a direction flip waits one cycle so Rc reflects the new direction
                        if (w_dir) begin
                            w_dir_n = ~r_cnt_dir;
                            w_pend  = w_due;
                        end else if (w_due) begin
                            w_pend  = 1'b0;
                            w_en    = ~bus.Rc | bus.auto_rev;
                            w_dir_n = r_cnt_dir ^ (bus.Rc & bus.auto_rev);
                            w_state = (bus.Rc & ~bus.auto_rev) ? S_END : S_RUN;
                        end
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!RST_n) begin
            r_state   <= S_IDLE;
            r_cnt_en  <= 1'b0;
            r_cnt_dir <= DIR_UP;
            r_cnt_clr <= 1'b1;
            r_les     <= LES_NONE;
            r_points  <= POINTS_OFF;
            r_presc   <= '0;
            r_pend    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt_en  <= w_en;
            r_cnt_dir <= w_dir_n;
            r_cnt_clr <= w_clr;
            r_les     <= (w_state == S_PAUSE || w_state == S_END) ? LES_BLINK_ALL : LES_NONE;
            r_points  <= points_for(w_dir_n);
            r_presc   <= w_presc;
            r_pend    <= w_pend;
        end
    end
    assign bus.state   = r_state;
    assign bus.cnt_en  = r_cnt_en;
    assign bus.cnt_dir = r_cnt_dir;
    assign bus.cnt_clr = r_cnt_clr;
    assign bus.LES     = r_les;
    assign bus.points  = r_points;
endmodule

// File: doc/rev_counter_seq.md
Name: rev_counter_seq

Overview:
- Sequencer for the 16-bit reversible counter datapath and the 4-digit display.
- Replaces the free-running slow-clock drive of the counter with single-clock, enable-based control.
- Debounces three user buttons and runs a run/pause/end state machine.
- Emits per-tick count enables, direction, and clear to the counter; emits blink/point controls to the display driver.

Parameters:
- TICK_DIV, 10000000, clk cycles per count tick (100 ms at 100 MHz); must be >= 2.
- DB_CYCLES, 1000000, cycles a synchronised button level must be stable before it is accepted; must be >= 1.

Ports:
- clk  in  1  system clock
- RST_n  in  1  synchronous reset, active-low
- btn_run  in  1  raw async button; press toggles run/pause
- btn_dir  in  1  raw async button; press toggles count direction
- btn_clr  in  1  raw async button; press clears counter, returns to IDLE
- auto_rev  in  1  level; 1 = reverse direction at terminal count, 0 = stop at terminal count
- Rc  in  1  counter terminal-count flag for the current direction (combinational from counter)
- cnt_en  out  1  one-cycle count-enable pulse
- cnt_dir  out  1  1 = up, 0 = down
- cnt_clr  out  1  synchronous clear to counter
- state  out  2  FSM state, for debug
- LES  out  4  display blink mask
- points  out  4  display decimal points; 0 = lit

Behaviour:
- Reset: clk and RST_n; synchronous, active-low.
- Reset values (registered, while RST_n=0): state=IDLE, cnt_en=0, cnt_dir=1, cnt_clr=1, LES=4'b0000, points=4'b1111, prescaler=0.
  - cnt_clr drops on the first cycle after release.
  - Reset mid-run aborts immediately; there is no pending pulse.
- Button path, per button:
  - 2-FF synchroniser, then a stability counter.
  - The debounced level updates once the synced level has differed from it for DB_CYCLES consecutive cycles.
  - A press is the rising edge of the debounced level: a one-cycle pulse.
  - Press latency from a clean raw edge = 2 + DB_CYCLES + 1 cycles. Bounces shorter than DB_CYCLES produce no pulse.
- States: IDLE=0, RUN=1, PAUSE=2, END=3.
- Priority when presses coincide in one cycle: clr > run > dir. Lower-priority presses in that cycle are discarded.
- clr press, any state:
  - Next state IDLE.
  - cnt_clr=1 for exactly one cycle.
  - cnt_dir unchanged; prescaler reset.
- IDLE: run press -> RUN, prescaler=0. dir press toggles cnt_dir.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. Tick when prescaler=TICK_DIV-1, then it wraps to 0.
  - First tick comes exactly TICK_DIV cycles after entry to RUN.
  - Tick with Rc=0: cnt_en=1 for one cycle, cnt_dir unchanged.
  - Tick with Rc=1, auto_rev=1: cnt_dir toggles and cnt_en=1 in the same cycle. The count steps in the new direction (0xFFFF -> 0xFFFE; 0x0000 -> 0x0001).
  - Tick with Rc=1, auto_rev=0: no cnt_en; next state END.
  - run press -> PAUSE; prescaler holds.
  - dir press toggles cnt_dir. If the press coincides with a tick, the toggle applies first and the tick uses the new direction and new Rc.
- PAUSE:
  - run press -> RUN, resuming the held prescaler phase.
  - dir press toggles cnt_dir and stays in PAUSE.
  - cnt_en=0.
- END:
  - cnt_en=0.
  - dir press toggles cnt_dir and moves to PAUSE.
  - run press is ignored.
- cnt_en is never asserted outside RUN and never in the same cycle as cnt_clr.
- LES = 4'b1111 in PAUSE and END, 4'b0000 otherwise.
- points = 4'b1110 when cnt_dir=0 (down indicator), else 4'b1111.
- All outputs are registered; cnt_en is a registered pulse one cycle after the tick condition.

Decomposition:
- Shared package: state encodings (IDLE/RUN/PAUSE/END), DIR_UP=1'b1, LES_BLINK_ALL/LES_NONE, POINTS_OFF.
- One sub-module, btn_debounce:
  - Parameter: DB_CYCLES.
  - Ports: clk, RST_n, raw, level, press.
  - Instantiated three times.
- Prescaler and FSM live in rev_counter_seq.

Test Plan (TICK_DIV=4, DB_CYCLES=3, behavioural counter model):
- Reset, then clean run press:
  - cnt_clr=1 only during reset.
  - press pulse 6 cycles after raw edge.
  - RUN entered; cnt_en pulses every 4 cycles, first at +4.
  - model count 0 -> 1 -> 2.
- Raw run button toggling every 2 cycles for 20 cycles, then stable:
  - exactly one press.
  - state stays IDLE during the bounce, then RUN.
- Model preloaded to 0xFFFE, up, auto_rev=0:
  - ticks give 0xFFFF.
  - next tick: no cnt_en, state=END, LES=1111.
  - dir press -> PAUSE, cnt_dir=0, points=1110.
- Model at 0xFFFF, up, auto_rev=1:
  - tick toggles cnt_dir to 0 with cnt_en in the same cycle.
  - count 0xFFFE, then 0xFFFD.
- Pause and clear:
  - run press in RUN at prescaler=2 -> PAUSE, no cnt_en.
  - resume: next cnt_en after 1 more cycle.
  - clr and run pressed in the same cycle -> IDLE, one cnt_clr pulse, cnt_en=0.
- RST_n driven low mid-RUN between ticks:
  - next edge shows all reset values.
  - no cnt_en for the following 8 cycles after release.
